// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble 1,0,1, payload MSB first, optional even parity (SEQ_FRAME_TX_PARITY_EN), one guard zero.
// First bit appears one edge after an accepted start; start is ignored (not queued) while busy.
module seq_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ($clog2(DATA_W) > 2) ? $clog2(DATA_W) : 2;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
`ifdef SEQ_FRAME_TX_PARITY_EN
        S_PAR,
`endif
        S_GUARD
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              sout_q;
    logic              busy_q;
    logic              done_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic              par_q;
`endif

    // State names the bit currently on sout; cnt_q is that bit's index within the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    sout_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_PRE;
                        cnt_q   <= '0;
                        shift_q <= din;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        par_q   <= ^din;
`endif
                        sout_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (cnt_q == CNT_PRE) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                        sout_q  <= shift_q[DATA_W-1];
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    end else begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        // preamble index 1 is the 0, index 2 the closing 1
                        sout_q <= (cnt_q == CNT_ONE);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state_q <= S_PAR;
                        sout_q  <= par_q;
`else
                        state_q <= S_GUARD;
                        sout_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        sout_q  <= shift_q[DATA_W-1];
                        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    end
                end
`ifdef SEQ_FRAME_TX_PARITY_EN
                S_PAR: begin
                    state_q <= S_GUARD;
                    sout_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
`endif
                S_GUARD: begin
                    state_q <= S_IDLE;
                    sout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    sout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Randomized bench for seq_frame_tx against a frame-level model, plus literal frame checks.
module tb_seq_frame_tx;

    localparam int DW = 8;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int FL = DW + 4;
    localparam logic [15:0] EXP07 = 16'hA0F0;
`else
    localparam int FL = DW + 3;
    localparam logic [15:0] EXP07 = 16'hA0E0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          sout, busy, done;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic busy_prev = 1'b0;

    seq_frame_tx #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase = cycles since the accepting edge, -1 when idle.
    int phase = -1;
    int fr[0:FL-1];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase = -1;
        end else if ((phase < 0 || phase == FL + 1) && start) begin
            fr[0] = 1; fr[1] = 0; fr[2] = 1;
            for (int i = 0; i < DW; i++) fr[3+i] = int'(din[DW-1-i]);
`ifdef SEQ_FRAME_TX_PARITY_EN
            fr[3+DW] = $countones(din) % 2;
`endif
            phase = 0;
        end else if (phase == FL + 1) begin
            phase = -1;
        end else if (phase >= 0) begin
            phase = phase + 1;
        end
    end

    always @(negedge clk) begin
        logic es, eb, ed;
        es = (phase >= 0 && phase < FL) ? fr[phase][0] : 1'b0;
        eb = (phase >= 0 && phase <= FL);
        ed = (phase == FL);
        chk("sout", 32'(sout), 32'(es));
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        if (busy && !busy_prev) rises++;
        busy_prev = busy;
    end

    task automatic lit_frame(input logic [DW-1:0] d, input logic [15:0] exp, input string nm);
        logic [15:0] got;
        int bc;
        got = '0;
        bc  = 0;
        @(negedge clk); start = 1'b1; din = d;
        @(negedge clk); start = 1'b0; din = ~d;
        for (int k = 0; k < FL; k++) begin
            got[15-k] = sout;
            if (busy) bc++;
            @(negedge clk);
        end
        chk({nm, "_done_hi"}, 32'(done), 32'd1);
        if (busy) bc++;
        @(negedge clk);
        chk({nm, "_done_lo"}, 32'(done), 32'd0);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        chk({nm, "_bits"}, 32'(got), 32'(exp));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(FL + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 reset = 1'b1;

        lit_frame(8'hA5, 16'hB4A0, "a5");
        lit_frame(8'h07, EXP07, "x07");

        // Reset in the middle of the payload
        @(negedge clk); start = 1'b1; din = 8'h3C;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_sout", 32'(sout), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_sout", 32'(sout), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        lit_frame(8'h0F, 16'hA1E0, "x0f");

        // start held high: back-to-back frames, payload disturbed mid-frame
        rises = 0;
        @(negedge clk); start = 1'b1; din = 8'hFF;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            din = ((i % (FL + 2)) inside {[3:8]}) ? DW'($urandom) : 8'hFF;
        end
        start = 1'b0;
        repeat (FL + 3) @(negedge clk);
        chk("b2b_frames", 32'(rises), 32'd3);

        // start pulses during payload and guard are ignored
        rises = 0;
        @(negedge clk); start = 1'b1; din = 8'h5A;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; din = 8'hC3;
        @(negedge clk); start = 1'b0;
        repeat (FL - 6) @(negedge clk);
        chk("guard_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored_starts", 32'(rises), 32'd1);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            din   = DW'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                #2 reset = 1'b0;
                #1;
                chk("rnd_rst_sout", 32'(sout), 32'd0);
                chk("rnd_rst_busy", 32'(busy), 32'd0);
                @(negedge clk); #2 reset = 1'b1;
            end
        end
        start = 1'b0;
        repeat (FL + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
